// File: rtl/uart_pkg.sv
// Shared types and constants for the UART program loader.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [31:0] TERMINATOR      = 32'hFFFF_FFFF;
  localparam int          DEFAULT_CLK_DIV = 868;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer plus mid-bit sampling FSM.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       byte_ready,
  output logic [7:0] byte_next
);

  localparam int             TW   = $clog2(CLK_DIV);
  localparam logic [TW-1:0]  HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0]  LAST = TW'(CLK_DIV - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     state;
  rx_state_t     state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic          bad_stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_next;
      timer      <= timer_next;
      bit_idx    <= bit_next;
      shift_reg  <= shift_next;
      byte_valid <= byte_ready;
      frame_err  <= bad_stop;
      if (byte_ready) begin
        rx_data <= shift_reg;
      end
    end
  end

  // The stop bit is judged at its midpoint and the FSM returns to IDLE at once,
  // so a following start bit with no idle gap is still caught.
  always_comb begin
    state_next = state;
    timer_next = timer + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    byte_ready = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (!rx_sync) begin
          state_next = START;
        end
      end
      START: begin
        if (timer == HALF) begin
          timer_next = '0;
          bit_next   = '0;
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == LAST) begin
          timer_next = '0;
          shift_next = {rx_sync, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (timer == LAST) begin
          timer_next = '0;
          state_next = IDLE;
          if (rx_sync) begin
            byte_ready = 1'b1;
          end else begin
            bad_stop = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign byte_next = shift_reg;

endmodule

// File: rtl/uart_word_loader.sv
// Assembles received UART bytes big-endian into 32-bit words and writes them to memory.
module uart_word_loader
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [7:0]        rx_data,
  output logic              byte_valid,
  output logic              we,
  output logic [ADDR_W-1:0] memadr,
  output logic [31:0]       memdata,
  output logic [31:0]       rx_check,
  output logic              frame_err,
  output logic              done
);

  logic              byte_ready;
  logic [7:0]        byte_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       full_word;

  uart_rx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .byte_ready(byte_ready),
    .byte_next (byte_next)
  );

  assign full_word = {word_buf, byte_next};

  // Acting on byte_ready (the edge that raises byte_valid) lines we up with
  // the byte_valid of the fourth byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      word_buf <= '0;
      word_idx <= '0;
      we       <= 1'b0;
      memadr   <= '0;
      memdata  <= '0;
      rx_check <= '0;
      done     <= 1'b0;
    end else begin
      we <= 1'b0;
      if (we) begin
        word_idx <= word_idx + 1'b1;
        if (rx_check != '1) begin
          rx_check <= rx_check + 32'd1;
        end
      end
      if (byte_ready && !done) begin
        if (byte_cnt == 2'd3) begin
          byte_cnt <= '0;
          if (full_word == TERMINATOR) begin
            done <= 1'b1;
          end else begin
            we      <= 1'b1;
            memadr  <= word_idx;
            memdata <= full_word;
          end
        end else begin
          word_buf <= {word_buf[15:0], byte_next};
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: table-driven byte stream plus a scoreboard.
module tb_uart_word_loader;

  localparam int CLK_DIV = 16;
  localparam int ADDR_W  = 2;

  logic              clk;
  logic              reset;
  logic              rx;
  logic [7:0]        rx_data;
  logic              byte_valid;
  logic              we;
  logic [ADDR_W-1:0] memadr;
  logic [31:0]       memdata;
  logic [31:0]       rx_check;
  logic              frame_err;
  logic              done;

  uart_word_loader #(
    .CLK_DIV(CLK_DIV),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .we        (we),
    .memadr    (memadr),
    .memdata   (memdata),
    .rx_check  (rx_check),
    .frame_err (frame_err),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        data;
    logic              stop;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_adr;
    logic [31:0]       exp_word;
    logic [31:0]       exp_check;
    logic              exp_done;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         bv_count = 0;
  int         ferr_count = 0;
  int         ferr_pending = 0;
  logic [7:0] byte_q[$];
  wr_t        wr_q[$];
  vec_t       vecs[29];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every DUT pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (byte_valid) begin
      bv_count++;
      if (byte_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte_valid: got rx_data %h expected no byte", rx_data);
      end else begin
        check_output("rx_data", 32'(rx_data), 32'(byte_q.pop_front()));
      end
    end
    if (frame_err) begin
      ferr_count++;
      checks++;
      if (ferr_pending == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_frame_err: got 1 expected 0");
      end else begin
        ferr_pending--;
      end
    end
    if (we) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_we: got adr %h data %h expected no write", memadr, memdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check_output("memadr", 32'(memadr), 32'(w.adr));
        check_output("memdata", memdata, w.data);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    if (v.stop) byte_q.push_back(v.data);
    else ferr_pending++;
    if (v.exp_we) wr_q.push_back('{v.exp_adr, v.exp_word});
    send_byte(v.data, v.stop);
    if (!v.stop) idle(2 * CLK_DIV);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    check_output({tag, "_byte_valid"}, 32'(byte_valid), 32'h0);
    check_output({tag, "_we"}, 32'(we), 32'h0);
    check_output({tag, "_memadr"}, 32'(memadr), 32'h0);
    check_output({tag, "_memdata"}, memdata, 32'h0);
    check_output({tag, "_rx_check"}, rx_check, 32'h0);
    check_output({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check_output({tag, "_done"}, 32'(done), 32'h0);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic s, input logic w,
                              input logic [ADDR_W-1:0] a, input logic [31:0] word,
                              input logic [31:0] chk, input logic dn);
    vec_t v;
    v.data = d; v.stop = s; v.exp_we = w; v.exp_adr = a;
    v.exp_word = word; v.exp_check = chk; v.exp_done = dn;
    return v;
  endfunction

  initial begin
    int bv_before;
    // First word at address 0
    vecs[0]  = mk(8'h12, 1, 0, 2'd0, 32'h0,          32'd0, 0);
    vecs[1]  = mk(8'h34, 1, 0, 2'd0, 32'h0,          32'd0, 0);
    vecs[2]  = mk(8'h56, 1, 0, 2'd0, 32'h0,          32'd0, 0);
    vecs[3]  = mk(8'h78, 1, 1, 2'd0, 32'h1234_5678,  32'd1, 0);
    // Two words back-to-back with no idle time
    vecs[4]  = mk(8'hA1, 1, 0, 2'd0, 32'h0,          32'd1, 0);
    vecs[5]  = mk(8'hB2, 1, 0, 2'd0, 32'h0,          32'd1, 0);
    vecs[6]  = mk(8'hC3, 1, 0, 2'd0, 32'h0,          32'd1, 0);
    vecs[7]  = mk(8'hD4, 1, 1, 2'd1, 32'hA1B2_C3D4,  32'd2, 0);
    vecs[8]  = mk(8'h0F, 1, 0, 2'd0, 32'h0,          32'd2, 0);
    vecs[9]  = mk(8'h1E, 1, 0, 2'd0, 32'h0,          32'd2, 0);
    vecs[10] = mk(8'h2D, 1, 0, 2'd0, 32'h0,          32'd2, 0);
    vecs[11] = mk(8'h3C, 1, 1, 2'd2, 32'h0F1E_2D3C,  32'd3, 0);
    // Bad stop bit inside a word must not shift the assembly
    vecs[12] = mk(8'h11, 1, 0, 2'd0, 32'h0,          32'd3, 0);
    vecs[13] = mk(8'hA5, 0, 0, 2'd0, 32'h0,          32'd3, 0);
    vecs[14] = mk(8'h22, 1, 0, 2'd0, 32'h0,          32'd3, 0);
    vecs[15] = mk(8'h33, 1, 0, 2'd0, 32'h0,          32'd3, 0);
    vecs[16] = mk(8'h44, 1, 1, 2'd3, 32'h1122_3344,  32'd4, 0);
    // Fifth word wraps the 2-bit address back to 0
    vecs[17] = mk(8'hDE, 1, 0, 2'd0, 32'h0,          32'd4, 0);
    vecs[18] = mk(8'hAD, 1, 0, 2'd0, 32'h0,          32'd4, 0);
    vecs[19] = mk(8'hBE, 1, 0, 2'd0, 32'h0,          32'd4, 0);
    vecs[20] = mk(8'hEF, 1, 1, 2'd0, 32'hDEAD_BEEF,  32'd5, 0);
    // Terminator, then bytes that must be ignored by the assembler
    vecs[21] = mk(8'hFF, 1, 0, 2'd0, 32'h0,          32'd5, 0);
    vecs[22] = mk(8'hFF, 1, 0, 2'd0, 32'h0,          32'd5, 0);
    vecs[23] = mk(8'hFF, 1, 0, 2'd0, 32'h0,          32'd5, 0);
    vecs[24] = mk(8'hFF, 1, 0, 2'd0, 32'h0,          32'd5, 1);
    vecs[25] = mk(8'h01, 1, 0, 2'd0, 32'h0,          32'd5, 1);
    vecs[26] = mk(8'h02, 1, 0, 2'd0, 32'h0,          32'd5, 1);
    vecs[27] = mk(8'h03, 1, 0, 2'd0, 32'h0,          32'd5, 1);
    vecs[28] = mk(8'h04, 1, 0, 2'd0, 32'h0,          32'd5, 1);

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    idle(4);

    // A short low glitch on the idle line must be rejected silently
    bv_before = bv_count;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idle(3 * CLK_DIV);
    check_output("glitch_byte_valid_count", 32'(bv_count), 32'(bv_before));
    check_output("glitch_frame_err_count", 32'(ferr_count), 32'h0);

    for (int i = 0; i < 29; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("row%0d_rx_check", i), rx_check, vecs[i].exp_check);
      check_output($sformatf("row%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end
    idle(2 * CLK_DIV);
    check_output("table_bytes_left", 32'(byte_q.size()), 32'h0);
    check_output("table_writes_left", 32'(wr_q.size()), 32'h0);
    check_output("table_frame_err_left", 32'(ferr_pending), 32'h0);
    check_output("table_frame_err_count", 32'(ferr_count), 32'd1);
    check_output("held_memadr", 32'(memadr), 32'h0);
    check_output("held_memdata", memdata, 32'hDEAD_BEEF);

    // Reset in the middle of a byte discards the partial byte and word
    reset = 1'b0;
    idle(2);
    check_all_zero("reset2");
    reset = 1'b1;
    idle(4);
    byte_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    byte_q.push_back(8'h6B);
    send_byte(8'h6B, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midbyte_reset");
    rx    = 1'b1;
    reset = 1'b1;
    idle(2 * CLK_DIV);
    byte_q.push_back(8'hCA);
    send_byte(8'hCA, 1'b1);
    byte_q.push_back(8'hFE);
    send_byte(8'hFE, 1'b1);
    byte_q.push_back(8'hBA);
    send_byte(8'hBA, 1'b1);
    byte_q.push_back(8'hBE);
    wr_q.push_back('{2'd0, 32'hCAFE_BABE});
    send_byte(8'hBE, 1'b1);
    idle(2 * CLK_DIV);
    check_output("after_reset_rx_check", rx_check, 32'd1);
    check_output("after_reset_done", 32'(done), 32'h0);
    check_output("after_reset_bytes_left", 32'(byte_q.size()), 32'h0);
    check_output("after_reset_writes_left", 32'(wr_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
